// File: rtl/sort_pkg.sv
// Shared sizes, types and helpers for the min-sort emitter.
package sort_pkg;

    localparam int unsigned M = 8;
    localparam int unsigned N = 8;

    // Index width that never collapses to zero for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IW = idx_width(M);

    typedef logic [M-1:0][N-1:0] chi_t;
    typedef logic [M-1:0]        mask_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } emit_state_t;

endpackage

// File: rtl/lsb_first_one.sv
// Combinational priority encoder: index of the lowest set bit plus a found flag.
module lsb_first_one #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [W-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan upward; the first hit wins so the lowest index is reported.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (mask[i] && !found) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/min_sort_emitter.sv
// Accepts one block of M words and emits them in ascending order (ties by lowest
// index), finding each minimum with a bit-serial MSB-first candidate-mask scan.
module min_sort_emitter #(
    parameter int unsigned  M  = sort_pkg::M,
    parameter int unsigned  N  = sort_pkg::N,
    localparam int unsigned IW = sort_pkg::idx_width(M)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [M-1:0][N-1:0]   i_chi,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [N-1:0]          o_data,
    output logic [IW-1:0]         o_idx,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy
);
    import sort_pkg::*;

    localparam int unsigned BW     = idx_width(N);
    localparam logic [BW-1:0] BitTop = BW'(N - 1);

    emit_state_t           state_q, state_d;
    logic [M-1:0][N-1:0]   word_q, word_d;
    logic [M-1:0]          active_q, active_d;
    logic [M-1:0]          cand_q, cand_d;
    logic [BW-1:0]         bit_q, bit_d;

    logic [IW-1:0]         cand_idx, act_idx;
    logic                  cand_found, act_found;
    logic [M-1:0]          slice, z, sel_onehot, act_rest;
    logic                  single;

    lsb_first_one #(.W(M), .IW(IW)) u_cand_enc (
        .mask  (cand_q),
        .idx   (cand_idx),
        .found (cand_found)
    );

    lsb_first_one #(.W(M), .IW(IW)) u_active_enc (
        .mask  (active_q),
        .idx   (act_idx),
        .found (act_found)
    );

    // Current bit slice, surviving candidates, and the last-remaining test.
    always_comb begin
        slice = '0;
        for (int k = 0; k < int'(M); k++) begin
            slice[k] = word_q[k][bit_q];
        end
        z          = cand_q & ~slice;
        sel_onehot = M'(1) << cand_idx;
        // Exactly one active bit: clearing the lowest one leaves nothing.
        act_rest   = active_q & ~(M'(1) << act_idx);
        single     = act_found && (act_rest == '0);
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid) state_d = SCAN;
            SCAN:    if (bit_q == '0) state_d = EMIT;
            EMIT:    if (i_ready) state_d = single ? IDLE : SCAN;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, decoded from registered state only.
    always_comb begin
        o_ready = (state_q == IDLE);
        o_busy  = (state_q != IDLE);
        o_valid = (state_q == EMIT) && cand_found;
        o_idx   = o_valid ? cand_idx : '0;
        o_data  = o_valid ? word_q[cand_idx] : '0;
        o_last  = o_valid && single;
    end

    // Datapath next state: load, one slice per SCAN cycle, retire on handshake.
    always_comb begin
        word_d   = word_q;
        active_d = active_q;
        cand_d   = cand_q;
        bit_d    = bit_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    word_d   = i_chi;
                    active_d = '1;
                    cand_d   = '1;
                    bit_d    = BitTop;
                end
            end
            SCAN: begin
                // An empty z means every candidate shares this bit; keep them all.
                if (z != '0) cand_d = z;
                if (bit_q != '0) bit_d = bit_q - 1'b1;
            end
            EMIT: begin
                if (i_ready) begin
                    active_d = active_q & ~sel_onehot;
                    if (single) begin
                        cand_d = '0;
                    end else begin
                        cand_d = active_q & ~sel_onehot;
                        bit_d  = BitTop;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_q   <= '0;
            active_q <= '0;
            cand_q   <= '0;
            bit_q    <= BitTop;
        end else begin
            word_q   <= word_d;
            active_q <= active_d;
            cand_q   <= cand_d;
            bit_q    <= bit_d;
        end
    end

endmodule

// File: tb/tb_min_sort_emitter.sv
// Directed and randomised checks of min_sort_emitter at M=4, N=4.
module tb_min_sort_emitter;

    localparam int unsigned M  = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [M-1:0][N-1:0] chi;
    logic                in_valid;
    logic                ready;
    logic [N-1:0]        data;
    logic [IW-1:0]       idx;
    logic                out_valid;
    logic                down_ready;
    logic                last;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;

    min_sort_emitter #(.M(M), .N(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_chi   (chi),
        .i_valid (in_valid),
        .o_ready (ready),
        .o_data  (data),
        .o_idx   (idx),
        .o_valid (out_valid),
        .i_ready (down_ready),
        .o_last  (last),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_block(input int w0, input int w1, input int w2, input int w3);
        chi[0] = 4'(w0);
        chi[1] = 4'(w1);
        chi[2] = 4'(w2);
        chi[3] = 4'(w3);
    endtask

    task automatic load(input int w0, input int w1, input int w2, input int w3);
        set_block(w0, w1, w2, w3);
        in_valid = 1'b1;
        chk("load_ready", ready, 1);
        tick;
        in_valid = 1'b0;
    endtask

    // Waits for the next word, checks it and its latency, optionally stalls, then handshakes.
    task automatic expect_word(input string tag, input int v, input int ix, input int lst,
                               input int stall);
        int cnt = 0;
        while (!out_valid && cnt < 64) begin
            tick;
            cnt++;
        end
        chk({tag, "_gap"}, cnt, N);
        chk({tag, "_data"}, data, v);
        chk({tag, "_idx"}, idx, ix);
        chk({tag, "_last"}, last, lst);
        chk({tag, "_ready"}, ready, 0);
        if (stall > 0) begin
            down_ready = 1'b0;
            repeat (stall) begin
                tick;
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_data"}, data, v);
                chk({tag, "_hold_idx"}, idx, ix);
                chk({tag, "_hold_ready"}, ready, 0);
            end
            down_ready = 1'b1;
        end
        tick;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_idle_ready"}, ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        logic [N-1:0] rv [M];
        int           order [M];
        bit           used [M];
        int           best;
        bit           got;
        int           cnt;

        rst        = 1'b1;
        in_valid   = 1'b0;
        chi        = '0;
        down_ready = 1'b1;
        tick;
        tick;
        chk("rst_ready", ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_idx", idx, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick;

        // Distinct values, no stalls.
        load(9, 3, 12, 5);
        chk("t1_busy", busy, 1);
        expect_word("t1_w0", 3, 1, 0, 0);
        expect_word("t1_w1", 5, 3, 0, 0);
        expect_word("t1_w2", 9, 0, 0, 0);
        expect_word("t1_w3", 12, 2, 1, 0);
        check_idle("t1");

        // Ties and extremes.
        load(7, 0, 7, 0);
        expect_word("t2_w0", 0, 1, 0, 0);
        expect_word("t2_w1", 0, 3, 0, 0);
        expect_word("t2_w2", 7, 0, 0, 0);
        expect_word("t2_w3", 7, 2, 1, 0);
        check_idle("t2");

        load(15, 15, 15, 15);
        expect_word("t3_w0", 15, 0, 0, 0);
        expect_word("t3_w1", 15, 1, 0, 0);
        expect_word("t3_w2", 15, 2, 0, 0);
        expect_word("t3_w3", 15, 3, 1, 0);
        check_idle("t3");

        // Backpressure: six stall cycles at every word.
        load(9, 3, 12, 5);
        expect_word("t4_w0", 3, 1, 0, 6);
        expect_word("t4_w1", 5, 3, 0, 6);
        expect_word("t4_w2", 9, 0, 0, 6);
        expect_word("t4_w3", 12, 2, 1, 6);
        check_idle("t4");

        // i_valid held with new data mid-block is ignored, then taken right after o_last.
        set_block(9, 3, 12, 5);
        in_valid = 1'b1;
        tick;
        set_block(1, 1, 1, 1);
        expect_word("t5_w0", 3, 1, 0, 0);
        expect_word("t5_w1", 5, 3, 0, 2);
        expect_word("t5_w2", 9, 0, 0, 0);
        expect_word("t5_w3", 12, 2, 1, 0);
        chk("t5_b2b_ready", ready, 1);
        tick;
        in_valid = 1'b0;
        chk("t5_b2b_busy", busy, 1);
        expect_word("t5_n0", 1, 0, 0, 0);
        expect_word("t5_n1", 1, 1, 0, 0);
        expect_word("t5_n2", 1, 2, 0, 0);
        expect_word("t5_n3", 1, 3, 1, 0);
        check_idle("t5");

        // Reset while the third word is being presented.
        load(9, 3, 12, 5);
        expect_word("t6_w0", 3, 1, 0, 0);
        expect_word("t6_w1", 5, 3, 0, 0);
        down_ready = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 64) begin
            tick;
            cnt++;
        end
        chk("t6_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_idx", idx, 0);
        chk("t6_rst_last", last, 0);
        chk("t6_rst_ready", ready, 1);
        chk("t6_rst_busy", busy, 0);
        tick;
        rst = 1'b0;
        down_ready = 1'b1;
        tick;
        load(1, 2, 3, 4);
        expect_word("t6_n0", 1, 0, 0, 0);
        expect_word("t6_n1", 2, 1, 0, 0);
        expect_word("t6_n2", 3, 2, 0, 0);
        expect_word("t6_n3", 4, 3, 1, 0);
        check_idle("t6");

        // Random blocks with random downstream readiness.
        for (int b = 0; b < 1000; b++) begin
            for (int k = 0; k < int'(M); k++) begin
                rv[k]   = N'($urandom_range(0, 15));
                used[k] = 1'b0;
            end
            // Stable order by (value, index).
            for (int r = 0; r < int'(M); r++) begin
                best = -1;
                for (int k = 0; k < int'(M); k++) begin
                    if (!used[k] && (best < 0 || rv[k] < rv[best])) best = k;
                end
                order[r]   = best;
                used[best] = 1'b1;
            end
            load(int'(rv[0]), int'(rv[1]), int'(rv[2]), int'(rv[3]));
            for (int r = 0; r < int'(M); r++) begin
                got = 1'b0;
                for (int c = 0; c < 100 && !got; c++) begin
                    down_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && down_ready) begin
                        chk("rnd_data", data, rv[order[r]]);
                        chk("rnd_idx", idx, order[r]);
                        chk("rnd_last", last, (r == int'(M) - 1) ? 1 : 0);
                        got = 1'b1;
                    end
                    tick;
                end
                chk("rnd_handshake", got, 1);
            end
            down_ready = 1'b1;
            chk("rnd_idle_ready", ready, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/min_sort_emitter.md
Name: min_sort_emitter

Overview:
- Sequential consumer/back end of the bit-slice min-search used in the min_sort datapath. Accepts one block of M words of N bits, then emits them one per handshake in ascending order, with ties broken by lowest index.
- Each minimum is found by a bit-serial MSB→LSB candidate-mask scan, one bit slice per cycle. This replaces the fully combinational slice chain with one iterated slice.
- Sits between the sort-input buffer and the downstream stream sink.

Parameters:
- M, sort_pkg::M (default 8): number of words per block.
- N, sort_pkg::N (default 8): word width in bits.
- IW, $clog2(M) (minimum 1): index width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_chi  in  [M-1:0][N-1:0]  input block
- i_valid  in  1  block valid
- o_ready  out  1  block accepted when i_valid && o_ready
- o_data  out  [N-1:0]  current minimum word
- o_idx  out  [IW-1:0]  original index of o_data
- o_valid  out  1  output word valid
- i_ready  in  1  downstream ready
- o_last  out  1  qualifies the final word of the block
- o_busy  out  1  block in progress (state != IDLE)

Behaviour:
- Reset (async, i_rst=1): state=IDLE; active mask=0; cand=0; bit counter=N-1; all outputs 0 except o_ready=1. A reset mid-block discards the block with no partial output.
- State machine: IDLE → SCAN → EMIT → (SCAN | IDLE).
- IDLE:
  - o_ready=1.
  - On load handshake: capture i_chi into the word register, set active={M{1}}, cand={M{1}}, bit counter=N-1, go to SCAN.
  - i_chi is sampled only at this edge.
- SCAN, one cycle per bit j = N-1 down to 0:
  - z = cand & ~slice_j, where slice_j[k] = word[k][j].
  - If z != 0 then cand ← z; otherwise cand is unchanged. This covers all-ones and all-zeros slices.
  - After processing j=0, go to EMIT.
  - Exactly N SCAN cycles per element.
- EMIT:
  - o_valid=1.
  - o_idx = lowest set bit of cand; o_data = word[o_idx].
  - o_last=1 iff active has exactly one bit set.
  - All outputs are stable while i_ready=0.
- EMIT handshake (o_valid && i_ready):
  - Clear active[o_idx].
  - If o_last: go to IDLE, with o_ready=1 in the next cycle.
  - Otherwise: cand ← new active mask, bit counter=N-1, go to SCAN.
- Latency: the first o_valid occurs N cycles after the load edge. Each following element arrives N cycles after the previous handshake, so zero-stall throughput is 1 word per N+1 cycles.
- o_ready=0 in SCAN and EMIT; i_valid is ignored there, and there is no overlap with the next block.
- Duplicate values: emitted consecutively, in ascending index order.
- M=1: one SCAN pass, then one emission with o_last=1.
- N=1: one SCAN cycle per element.
- All outputs are registered or decoded from registered state; there is no combinational path from i_valid or i_ready to any output.

Decomposition:
- sort_pkg holds:
  - M, N
  - IW = $clog2(M), minimum 1
  - typedef chi_t = logic [M-1:0][N-1:0]
  - typedef mask_t = logic [M-1:0]
  - enum emit_state_t {IDLE, SCAN, EMIT}
- Sub-module lsb_first_one:
  - Combinational M-bit priority encoder, mask_t → index plus a found flag.
  - Also used for the o_last single-bit test.

Test Plan (M=4, N=4):
- Distinct values: load {w0=9, w1=3, w2=12, w3=5} with i_ready held 1. Required output: (3,idx1), (5,3), (9,0), (12,2,last). First o_valid 4 cycles after load; 5 cycles between outputs.
- Ties and extremes: load {7,0,7,0}. Required output: (0,1), (0,3), (7,0), (7,2,last). Also load all-15 → idx 0,1,2,3 in order, with last on idx 3.
- Backpressure: same as the first case, but i_ready=0 for 6 cycles at each EMIT. o_data/o_idx/o_valid stay stable; sequence unchanged; o_ready stays 0 until the cycle after the last handshake.
- Load rules:
  - i_valid held during SCAN/EMIT with different data → ignored; the original block completes.
  - A back-to-back new block is accepted the cycle after o_last handshakes.
- Reset mid-block: assert i_rst while in EMIT after 2 outputs. Outputs go to 0 immediately, with o_ready=1. A new load {1,2,3,4} then emits 1,2,3,4 with idx 0..3.
- Random regression: 1000 random blocks with random i_ready. Scoreboard checks a stable sort by (value, index); o_last fires exactly once per block.
